lzs_copy_ctrl: RTL and testbench
================================

Name: lzs_copy_ctrl

Overview:
- Sequencer for the LZS decoder's 2 KB history memory (de_* port side).
- Accepts decoded tokens (literal or offset/length match), generates history read/write addresses, and copies match bytes out of the history window one byte at a time.
- Each emitted byte is written back into the history at the running write pointer and handed downstream over a valid/ready byte stream.
- Sits between the LZS token parser and the output byte packer; history_mem selects this side when dc[5]=0.

Parameters:
- AW, 11, history address width; window = 2^AW bytes.
- LW, 12, match length field width.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- tok_valid  in  1  token present
- tok_ready  out  1  token accepted when tok_valid&tok_ready
- tok_type  in  1  0=literal, 1=match
- tok_lit  in  8  literal byte
- tok_off  in  AW  match offset (distance back from write pointer), 1..2^AW-1
- tok_len  in  LW  match length in bytes, >=1
- hist_clr  in  1  clear write pointer (new stream); honoured only in IDLE
- de_hraddr  out  AW  history read address
- de_hwaddr  out  AW  history write address (= write pointer)
- de_hwe  out  1  history write enable
- de_data  out  8  history write data
- de_hdata  in  8  history read data, valid the cycle after de_hraddr is presented
- out_valid  out  1  output byte valid
- out_ready  in  1  downstream accepts
- out_data  out  8  output byte
- busy  out  1  state != IDLE
- err  out  1  sticky illegal-token flag

Behaviour:
- Interface: one clock wb_clk_i; reset wb_rst_i is synchronous and active-high.
- Reset values: state=IDLE, wptr=0, rptr=0, remain=0, byte_q=0, err=0, tok_ready=0, out_valid=0, de_hwe=0. de_hwaddr=wptr=0, de_hraddr=rptr=0, de_data=out_data=byte_q=0.
- Reset mid-copy aborts the copy. Bytes already written stay in memory. Nothing partial is emitted afterwards.
- tok_ready=1 only in IDLE and not hist_clr.
- State IDLE:
  - hist_clr=1: wptr<=0, stay IDLE, no token accepted (clear wins over a simultaneous token).
  - Literal accept: byte_q<=tok_lit -> EMIT.
  - Match accept with tok_off!=0 and tok_len!=0: rptr<=wptr-tok_off (mod 2^AW), remain<=tok_len -> MRD.
  - Match with tok_off==0 or tok_len==0: token consumed, err<=1, no byte emitted, stay IDLE.
- State MRD: de_hraddr=rptr -> MLAT.
- State MLAT: byte_q<=de_hdata -> EMIT.
- State EMIT:
  - out_valid=1, out_data=byte_q, de_data=byte_q, de_hwaddr=wptr.
  - de_hwe=out_valid&out_ready, so the history write coincides with the output handshake. While stalled there is no write and byte_q holds.
  - On handshake: wptr<=wptr+1 (wraps 2^AW-1 -> 0).
  - Literal, or match with remain==1: -> IDLE.
  - Otherwise remain<=remain-1, rptr<=rptr+1 (wrap) -> MRD.
- Timing: match byte = 3 cycles min (MRD, MLAT, EMIT); literal = 2 cycles (IDLE accept, EMIT).
- Overlapping matches (offset < length, e.g. offset 1 run) are correct by construction. Each read is issued after the previous byte's write has completed, so the raddr==waddr bypass is never relied on.
- Offset greater than bytes written since clear: no error. Returns stale memory contents (LZS stream fault, not checked).
- err clears only on reset.

Decomposition:
- Shared package lzs_pkg: state encoding (IDLE, MRD, MLAT, EMIT), TOK_LIT/TOK_MATCH constants, default AW=11 and LW=12.
- No sub-module: a single FSM plus pointer and length counters.
- Instantiated beside history_mem in the decoder top.

Test Plan:
- Reset, then literals 0x41,0x42,0x43 with out_ready=1 -> out bytes 41,42,43; de_hwe pulses at hwaddr 0,1,2; wptr=3.
- After those, match off=3 len=5 -> out 41,42,43,41,42 (overlap wrap within match); reads rptr 0..4; wptr=8.
- Literal 0x55 then match off=1 len=4 -> out 55,55,55,55,55; every read address equals wptr-1 at its issue.
- wptr preset to 2046 via 2046 literals, then literals 0x01,0x02,0x03 -> writes at 2046, 2047, 0; a subsequent match off=2 len=2 reads addresses 2047, 0.
- Match off=0 len=4, then match off=5 len=0 -> tok_ready handshake each, no out_valid, err=1 sticky.
- out_ready low 5 cycles mid-match -> out_data stable, de_hwe=0 throughout the stall, byte resumes on release. hist_clr together with tok_valid in IDLE -> token not accepted, wptr=0.

Source files
------------

// File: rtl/lzs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lzs_pkg
// Brief    : Shared types and constants for the LZS copy controller.
// Revision : 1.0 - initial release
// ============================================================================
package lzs_pkg;

  // Default history address width (window = 2^AW bytes) and match length width
  localparam int AW_DEF = 11;
  localparam int LW_DEF = 12;

  // Token type encoding on tok_type
  localparam logic TOK_LIT   = 1'b0;
  localparam logic TOK_MATCH = 1'b1;

  // Copy sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MRD  = 2'd1,
    ST_MLAT = 2'd2,
    ST_EMIT = 2'd3
  } state_t;

endpackage : lzs_pkg
`default_nettype wire

// File: rtl/lzs_copy_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lzs_copy_ctrl
// Brief    : LZS history sequencer. Takes literal / match tokens, copies match
//            bytes out of the history window one at a time, writes every
//            emitted byte back at the write pointer and streams it downstream.
// Revision : 1.0 - initial release
// ============================================================================
module lzs_copy_ctrl
  import lzs_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int LW = LW_DEF
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          tok_valid,
  output logic          tok_ready,
  input  logic          tok_type,
  input  logic [7:0]    tok_lit,
  input  logic [AW-1:0] tok_off,
  input  logic [LW-1:0] tok_len,
  input  logic          hist_clr,
  output logic [AW-1:0] de_hraddr,
  output logic [AW-1:0] de_hwaddr,
  output logic          de_hwe,
  output logic [7:0]    de_data,
  input  logic [7:0]    de_hdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          busy,
  output logic          err
);

  localparam logic [AW-1:0] A_ONE = AW'(1);
  localparam logic [LW-1:0] L_ONE = LW'(1);

  state_t        state;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [LW-1:0] remain;
  logic [7:0]    byte_q;
  logic          err_q;

  // Handshake and memory-port views of the sequencer registers. Reset masks
  // the handshakes so an aborted copy never emits or writes a partial byte.
  always_comb begin
    tok_ready = (state == ST_IDLE) && !hist_clr && !wb_rst_i;
    out_valid = (state == ST_EMIT) && !wb_rst_i;
    de_hwe    = out_valid && out_ready;
    de_hraddr = rptr;
    de_hwaddr = wptr;
    de_data   = byte_q;
    out_data  = byte_q;
    busy      = (state != ST_IDLE);
    err       = err_q;
  end

  // Token intake, match read sequencing and per-byte pointer/length update
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state  <= ST_IDLE;
      wptr   <= '0;
      rptr   <= '0;
      remain <= '0;
      byte_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (hist_clr) begin
            // Clear takes priority; any pending token waits.
            wptr <= '0;
          end else if (tok_valid) begin
            if (tok_type == TOK_LIT) begin
              byte_q <= tok_lit;
              remain <= '0;
              state  <= ST_EMIT;
            end else if ((tok_off != '0) && (tok_len != '0)) begin
              rptr   <= wptr - tok_off;
              remain <= tok_len;
              state  <= ST_MRD;
            end else begin
              // Illegal match: consumed, flagged, nothing emitted.
              err_q <= 1'b1;
            end
          end
        end
        ST_MRD: begin
          state <= ST_MLAT;
        end
        ST_MLAT: begin
          byte_q <= de_hdata;
          state  <= ST_EMIT;
        end
        ST_EMIT: begin
          if (out_ready) begin
            wptr <= wptr + A_ONE;
            // remain is 0 for literals, so <=1 covers both final cases.
            if (remain <= L_ONE) begin
              remain <= '0;
              state  <= ST_IDLE;
            end else begin
              remain <= remain - L_ONE;
              rptr   <= rptr + A_ONE;
              state  <= ST_MRD;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : lzs_copy_ctrl
`default_nettype wire

// File: tb/tb_lzs_copy_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lzs_copy_ctrl
// Brief    : Self-checking bench for lzs_copy_ctrl with a history memory model
//            and a byte-level LZS reference decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lzs_copy_ctrl;

  localparam int AW  = 11;
  localparam int LW  = 12;
  localparam int WIN = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          tok_valid = 1'b0;
  logic          tok_ready;
  logic          tok_type = 1'b0;
  logic [7:0]    tok_lit = '0;
  logic [AW-1:0] tok_off = '0;
  logic [LW-1:0] tok_len = '0;
  logic          hist_clr = 1'b0;
  logic [AW-1:0] de_hraddr;
  logic [AW-1:0] de_hwaddr;
  logic          de_hwe;
  logic [7:0]    de_data;
  logic [7:0]    de_hdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [7:0]    out_data;
  logic          busy;
  logic          err;

  int checks = 0;
  int errors = 0;

  lzs_copy_ctrl #(.AW(AW), .LW(LW)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .tok_valid(tok_valid),
    .tok_ready(tok_ready),
    .tok_type (tok_type),
    .tok_lit  (tok_lit),
    .tok_off  (tok_off),
    .tok_len  (tok_len),
    .hist_clr (hist_clr),
    .de_hraddr(de_hraddr),
    .de_hwaddr(de_hwaddr),
    .de_hwe   (de_hwe),
    .de_data  (de_data),
    .de_hdata (de_hdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  // History RAM model: synchronous read, data one cycle after address
  logic [7:0] mem [WIN];
  always @(posedge clk) begin
    de_hdata <= mem[de_hraddr];
    if (de_hwe) mem[de_hwaddr] <= de_data;
  end

  // Reference decoder state: plain LZS history array and write position
  logic [7:0] ref_hist [WIN];
  int         ref_wptr = 0;

  typedef struct {
    logic [7:0]    data;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    bit            is_copy;
  } exp_t;
  exp_t exp_q[$];

  // Downstream backpressure: 0 = always ready, 1 = random, 2 = held low
  int bp_mode = 0;
  always @(posedge clk) begin
    #1;
    case (bp_mode)
      1:       out_ready = (($urandom % 4) != 0);
      2:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // Output stream monitor against the reference byte sequence
  bit mon_en = 1'b1;
  int hs_cnt = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (out_valid && out_ready) begin
        hs_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got data %02h at waddr %0d, required no output", out_data, de_hwaddr);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (out_data !== e.data || de_hwaddr !== e.waddr || de_hwe !== 1'b1 ||
              de_data !== e.data || (e.is_copy && de_hraddr !== e.raddr)) begin
            errors++;
            $display("FAIL stream_byte: got data %02h waddr %0d we %b raddr %0d, required data %02h waddr %0d we 1 raddr %0d",
                     out_data, de_hwaddr, de_hwe, de_hraddr, e.data, e.waddr, e.raddr);
          end
        end
      end else if (de_hwe !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL stray_write: got de_hwe %b without handshake, required 0", de_hwe);
      end
    end
  end

  // Reference model: expand a token into the byte sequence it must produce
  task automatic model_token(input logic ty, input logic [7:0] lit,
                             input int off, input int len);
    exp_t e;
    if (ty == 1'b0) begin
      e.data = lit; e.waddr = AW'(ref_wptr); e.raddr = '0; e.is_copy = 0;
      exp_q.push_back(e);
      ref_hist[ref_wptr] = lit;
      ref_wptr = (ref_wptr + 1) % WIN;
    end else if (off != 0 && len != 0) begin
      for (int i = 0; i < len; i++) begin
        int src;
        src = (ref_wptr - off + WIN) % WIN;
        e.data = ref_hist[src]; e.waddr = AW'(ref_wptr); e.raddr = AW'(src); e.is_copy = 1;
        exp_q.push_back(e);
        ref_hist[ref_wptr] = ref_hist[src];
        ref_wptr = (ref_wptr + 1) % WIN;
      end
    end
  endtask

  task automatic send_tok(input logic ty, input logic [7:0] lit, input int off,
                          input int len, output bit acc);
    int n = 0;
    acc = 0;
    @(negedge clk);
    tok_valid = 1'b1; tok_type = ty; tok_lit = lit;
    tok_off = AW'(off); tok_len = LW'(len);
    #1;
    while (!tok_ready && n < 500) begin
      @(negedge clk); #1; n++;
    end
    if (tok_ready) begin
      acc = 1;
      model_token(ty, lit, off, len);
      @(posedge clk); #1;
    end else begin
      checks++; errors++;
      $display("FAIL tok_timeout: got tok_ready 0 for %0d cycles, required 1", n);
    end
    tok_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || busy) && n < 5000) begin
      @(negedge clk); n++;
    end
    if (n >= 5000) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d bytes outstanding busy %b, required 0 / 0", exp_q.size(), busy);
    end
  endtask

  task automatic check_wptr(input string nm);
    checks++;
    if (de_hwaddr !== AW'(ref_wptr)) begin
      errors++;
      $display("FAIL %s: got wptr %0d, required %0d", nm, de_hwaddr, ref_wptr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tok_ready !== 1'b0 || out_valid !== 1'b0 || de_hwe !== 1'b0 || de_hwaddr !== '0 ||
        de_hraddr !== '0 || out_data !== 8'h00 || de_data !== 8'h00 || err !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rdy %b ov %b we %b wa %0d ra %0d od %02h dd %02h err %b busy %b, required all 0",
               tok_ready, out_valid, de_hwe, de_hwaddr, de_hraddr, out_data, de_data, err, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tok_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_ready: got tok_ready %b busy %b, required 1 0", tok_ready, busy);
    end
  endtask

  task automatic test_literals();
    bit acc;
    send_tok(1'b0, 8'h41, 0, 0, acc);
    send_tok(1'b0, 8'h42, 0, 0, acc);
    send_tok(1'b0, 8'h43, 0, 0, acc);
    wait_drain();
    check_wptr("literal_wptr");
  endtask

  task automatic test_overlap_match();
    bit acc;
    send_tok(1'b1, 8'h00, 3, 5, acc);
    wait_drain();
    check_wptr("overlap_wptr");
  endtask

  task automatic test_run();
    bit acc;
    send_tok(1'b0, 8'h55, 0, 0, acc);
    send_tok(1'b1, 8'h00, 1, 4, acc);
    wait_drain();
    check_wptr("run_wptr");
  endtask

  task automatic test_wrap();
    bit acc;
    while (ref_wptr != WIN - 2) send_tok(1'b0, 8'($urandom), 0, 0, acc);
    wait_drain();
    check_wptr("preset_wptr");
    send_tok(1'b0, 8'h01, 0, 0, acc);
    send_tok(1'b0, 8'h02, 0, 0, acc);
    send_tok(1'b0, 8'h03, 0, 0, acc);
    send_tok(1'b1, 8'h00, 2, 2, acc);
    wait_drain();
    check_wptr("wrap_wptr");
  endtask

  task automatic test_illegal();
    bit acc;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_initial: got %b, required 0", err);
    end
    send_tok(1'b1, 8'h00, 0, 4, acc);
    checks++;
    if (!acc) begin errors++; $display("FAIL illegal_off_accept: got 0, required 1"); end
    send_tok(1'b1, 8'h00, 5, 0, acc);
    checks++;
    if (!acc) begin errors++; $display("FAIL illegal_len_accept: got 0, required 1"); end
    repeat (5) @(negedge clk);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL illegal_err: got err %b busy %b, required 1 0", err, busy);
    end
    send_tok(1'b0, 8'h7e, 0, 0, acc);
    wait_drain();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b, required 1", err); end
  endtask

  task automatic test_stall();
    bit acc;
    logic [7:0] held;
    bit seen = 0;
    int base;
    int n = 0;
    base = hs_cnt;
    send_tok(1'b1, 8'h00, 7, 6, acc);
    while (hs_cnt < base + 2 && n < 100) begin @(negedge clk); n++; end
    bp_mode = 2;
    @(posedge clk); #2;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid) begin
        if (!seen) begin
          held = out_data; seen = 1;
        end else begin
          checks++;
          if (out_data !== held) begin
            errors++;
            $display("FAIL stall_hold: got %02h, required %02h", out_data, held);
          end
        end
      end
      checks++;
      if (de_hwe !== 1'b0) begin
        errors++;
        $display("FAIL stall_write: got de_hwe %b, required 0", de_hwe);
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL stall_valid: got out_valid 0, required 1"); end
    bp_mode = 0;
    wait_drain();
    check_wptr("stall_wptr");
  endtask

  task automatic test_random();
    bit acc;
    bp_mode = 1;
    for (int t = 0; t < 60; t++) begin
      if (($urandom % 3) == 0) send_tok(1'b0, 8'($urandom), 0, 0, acc);
      else send_tok(1'b1, 8'h00, int'($urandom_range(1, WIN - 1)), int'($urandom_range(1, 9)), acc);
    end
    wait_drain();
    bp_mode = 0;
    check_wptr("random_wptr");
  endtask

  task automatic test_clear();
    bit acc;
    @(negedge clk);
    hist_clr = 1'b1; tok_valid = 1'b1; tok_type = 1'b0; tok_lit = 8'hc3;
    #1;
    checks++;
    if (tok_ready !== 1'b0) begin errors++; $display("FAIL clear_ready: got %b, required 0", tok_ready); end
    @(negedge clk);
    hist_clr = 1'b0; tok_valid = 1'b0;
    ref_wptr = 0;
    #1;
    checks++;
    if (busy !== 1'b0 || de_hwaddr !== '0) begin
      errors++;
      $display("FAIL clear_state: got busy %b wptr %0d, required 0 0", busy, de_hwaddr);
    end
    send_tok(1'b0, 8'h99, 0, 0, acc);
    wait_drain();
    check_wptr("clear_wptr");
  endtask

  task automatic test_reset_midcopy();
    bit acc;
    int base;
    int n = 0;
    base = hs_cnt;
    send_tok(1'b1, 8'h00, 1, 20, acc);
    while (hs_cnt < base + 3 && n < 100) begin @(negedge clk); n++; end
    rst = 1'b1;
    mon_en = 1'b0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || de_hwaddr !== '0 || err !== 1'b0 || de_hwe !== 1'b0) begin
        errors++;
        $display("FAIL abort_idle: got ov %b busy %b wptr %0d err %b we %b, required 0 0 0 0 0",
                 out_valid, busy, de_hwaddr, err, de_hwe);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < WIN; i++) begin
      mem[i]      = 8'(i) ^ 8'ha5;
      ref_hist[i] = 8'(i) ^ 8'ha5;
    end
    test_reset();
    test_literals();
    test_overlap_match();
    test_run();
    test_wrap();
    test_illegal();
    test_stall();
    test_random();
    test_clear();
    test_reset_midcopy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_lzs_copy_ctrl
`default_nettype wire
